fb_pixel_writer: RTL and testbench

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

---
 rtl/fb_pixel_writer_pkg.sv | 31 +++
 rtl/fb_pixel_fifo.sv | 48 ++++
 rtl/fb_pixel_writer.sv | 128 ++++++++++++
 tb/tb_fb_pixel_writer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pixel_writer_pkg.sv
// rtl/fb_pixel_writer_pkg.sv - shared types, grid geometry and lane layout for the pixel writer
package fb_pixel_writer_pkg;

  localparam int GRID_W    = 80;
  localparam int GRID_H    = 60;
  localparam int LANE_W    = 3;
  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [6:0] gx;
    logic [5:0] gy;
    logic [2:0] rgb;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  // Two cells share one 6-bit word, so the linear cell index is halved.
  function automatic logic [12:0] cell_word(input logic [6:0] gx, input logic [5:0] gy);
    logic [12:0] lin;
    lin = 13'(gy) * 13'(GRID_W) + 13'(gx);
    return lin >> 1;
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// rtl/fb_pixel_fifo.sv - synchronous first-word-fall-through queue with occupancy output
module fb_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - queues screen pixels and read-modify-writes packed 2-cell framebuffer words
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int X_WIRE_WIDTH = 11,
  parameter int Y_WIRE_WIDTH = 10,
  parameter int RESOLUTION_H = 1280,
  parameter int RESOLUTION_V = 960,
  parameter int CELL_SHIFT   = 4,
  parameter int FB_AW        = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [X_WIRE_WIDTH-1:0] in_hpos,
  input  logic [Y_WIRE_WIDTH-1:0] in_vpos,
  input  logic [2:0]              in_rgb,
  output logic                    fifofull,
  output logic [FB_AW-1:0]        fb_addr,
  output logic                    fb_re,
  input  logic [5:0]              fb_rdata,
  output logic                    fb_we,
  output logic [5:0]              fb_wdata,
  output logic                    busy,
  output logic [15:0]             drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_WIRE_WIDTH-1:0] RES_H = X_WIRE_WIDTH'(RESOLUTION_H);
  localparam logic [Y_WIRE_WIDTH-1:0] RES_V = Y_WIRE_WIDTH'(RESOLUTION_V);

  wr_state_t  state;
  logic       stall_d;
  logic       lane;
  logic [2:0] rgb_q;
  logic [5:0] merged;

  logic       in_range;
  logic       offer;
  logic       push;
  logic       drop;
  logic       pop;
  pix_entry_t push_entry;
  pix_entry_t head;
  logic       q_empty;
  logic       q_full;
  logic [CW-1:0] q_count;
  logic [CW-1:0] occ_next;

  // Upstream registers its output, so it only sees our backpressure one cycle late.
  assign in_range = (in_hpos < RES_H) && (in_vpos < RES_V);
  assign offer    = in_valid && !stall_d;
  assign push     = offer && in_range && !q_full;
  assign drop     = offer && !in_range;
  assign pop      = (state == ST_IDLE) && !q_empty;

  assign push_entry.gx  = in_hpos[CELL_SHIFT +: 7];
  assign push_entry.gy  = in_vpos[CELL_SHIFT +: 6];
  assign push_entry.rgb = in_rgb;

  assign occ_next = q_count + CW'(push) - CW'(pop);

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  always_comb begin
    merged = fb_rdata;
    if (lane) merged[LANE1_LSB +: LANE_W] = rgb_q;
    else      merged[LANE0_LSB +: LANE_W] = rgb_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      stall_d  <= 1'b0;
      fifofull <= 1'b0;
      fb_re    <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      drop_cnt <= '0;
      lane     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      stall_d  <= fifofull;
      // Two slots of headroom cover the push that lands while stall_d catches up.
      fifofull <= (occ_next >= CW'(FIFO_DEPTH - 2));
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      fb_re <= 1'b0;
      fb_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            fb_re   <= 1'b1;
            fb_addr <= FB_AW'(cell_word(head.gx, head.gy));
            lane    <= head.gx[0];
            rgb_q   <= head.rgb;
            state   <= ST_RD;
          end
        end
        ST_RD: state <= ST_WR;
        ST_WR: begin
          fb_we    <= 1'b1;
          fb_wdata <= merged;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = !q_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - directed self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] in_hpos = '0;
  logic [9:0]  in_vpos = '0;
  logic [2:0]  in_rgb = '0;
  logic        fifofull;
  logic [11:0] fb_addr;
  logic        fb_re;
  logic [5:0]  fb_rdata = '0;
  logic        fb_we;
  logic [5:0]  fb_wdata;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [5:0]  mem [0:2399] = '{default: 6'd0};
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [5:0]  pre_data = '0;
  logic [17:0] wlog [$];
  logic        tb_stall_d = 1'b0;
  logic        overlap = 1'b0;
  int          re_total = 0;

  fb_pixel_writer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_hpos  (in_hpos),
    .in_vpos  (in_vpos),
    .in_rgb   (in_rgb),
    .fifofull (fifofull),
    .fb_addr  (fb_addr),
    .fb_re    (fb_re),
    .fb_rdata (fb_rdata),
    .fb_we    (fb_we),
    .fb_wdata (fb_wdata),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (fb_we) mem[fb_addr] <= fb_wdata;
    if (fb_re) fb_rdata <= mem[fb_addr];
    if (rst && fb_we) wlog.push_back({fb_addr, fb_wdata});
    if (fb_re && fb_we) overlap <= 1'b1;
    if (fb_re) re_total <= re_total + 1;
    tb_stall_d <= rst ? fifofull : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [5:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic single_pixel(input string t, input logic [10:0] h, input logic [9:0] v,
                              input logic [2:0] c, input logic [11:0] ea, input logic [5:0] ed);
    in_valid = 1'b1; in_hpos = h; in_vpos = v; in_rgb = c;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({t, "_re"}, 32'(fb_re), 1);
    chk({t, "_re_addr"}, 32'(fb_addr), 32'(ea));
    chk({t, "_busy"}, 32'(busy), 1);
    @(negedge clk);
    chk({t, "_gap"}, 32'({fb_re, fb_we}), 0);
    @(negedge clk);
    chk({t, "_we"}, 32'(fb_we), 1);
    chk({t, "_we_addr"}, 32'(fb_addr), 32'(ea));
    chk({t, "_wdata"}, 32'(fb_wdata), 32'(ed));
    @(negedge clk);
    chk({t, "_we_pulse"}, 32'(fb_we), 0);
    chk({t, "_mem"}, 32'(mem[ea]), 32'(ed));
  endtask

  initial begin
    int k, pops, occ, maxocc, re_before;
    logic seen;
    logic [17:0] e;

    repeat (3) @(negedge clk);
    chk("rst_fifofull", 32'(fifofull), 0);
    chk("rst_re_we", 32'({fb_re, fb_we}), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_wdata", 32'(fb_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    preload(12'd0, 6'b111000);
    single_pixel("px_first", 11'd16, 10'd0, 3'b101, 12'd0, 6'b101000);
    preload(12'd2399, 6'b000000);
    single_pixel("px_corner", 11'd1279, 10'd959, 3'b011, 12'd2399, 6'b011000);

    re_before = re_total;
    in_valid = 1'b1; in_hpos = 11'd1280; in_vpos = 10'd0; in_rgb = 3'b111;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_h", 32'(drop_cnt), 1);
    in_valid = 1'b1; in_hpos = 11'd0; in_vpos = 10'd960;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_v", 32'(drop_cnt), 2);
    repeat (4) @(negedge clk);
    chk("drop_no_re", 32'(re_total - re_before), 0);
    chk("drop_idle", 32'(busy), 0);

    wlog.delete();
    k = 0; pops = 0; maxocc = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic will;
      in_valid = 1'b1;
      in_hpos = 11'(32 * k + 16);
      in_vpos = 10'd32;
      in_rgb = 3'(k);
      will = !tb_stall_d;
      @(negedge clk);
      if (will) k++;
      if (fb_re) pops++;
      occ = k - pops;
      if (occ > maxocc) maxocc = occ;
      if (fifofull && !seen) begin
        seen = 1'b1;
        chk("stream_full_at_6", 32'(occ), 6);
      end
    end
    in_valid = 1'b0;
    chk("stream_full_seen", 32'(seen), 1);
    chk("stream_no_overflow", 32'(maxocc <= 7), 1);
    wait_idle(300);
    chk("stream_count", 32'(wlog.size()), 32'(k));
    for (int j = 0; j < k && j < wlog.size(); j++) begin
      e = wlog[j];
      chk($sformatf("stream_addr_%0d", j), 32'(e[17:6]), 32'(80 + j));
      chk($sformatf("stream_data_%0d", j), 32'(e[5:0]), 32'({3'(j), 3'b000}));
    end

    preload(12'd81, 6'b000111);
    in_valid = 1'b1; in_hpos = 11'd48; in_vpos = 10'd32; in_rgb = 3'b010;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_idle(100);
    chk("dup_final_word", 32'(mem[81]), 32'(6'b010111));

    preload(12'd405, 6'b101010);
    in_valid = 1'b1; in_hpos = 11'd160; in_vpos = 10'd160; in_rgb = 3'b111;
    @(negedge clk);
    in_hpos = 11'd176;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_rd_re", 32'(fb_re), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", 32'(fb_we), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_full", 32'(fifofull), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_we", 32'(fb_we), 0);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("post_rst_mem", 32'(mem[405]), 32'(6'b101010));
    chk("no_re_we_overlap", 32'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
